// File: rtl/issue_queue_ooo_if.sv
// Handshake bundle between rename, the issue queue and execute.
// The queue uses the slave modport; the rename/execute side uses master.
interface issue_queue_ooo_if #(
   parameter int DEPTH      = 32,
   parameter int PREG_W     = 6,
   parameter int PAYLOAD_W  = 64,
   parameter int ID_W       = 32,
   parameter int WAKE_PORTS = 2
);
   logic                         enq_valid;
   logic                         enq_ready;
   logic [PAYLOAD_W-1:0]         enq_payload;
   logic                         enq_src0_used;
   logic                         enq_src1_used;
   logic [PREG_W-1:0]            enq_src0_tag;
   logic [PREG_W-1:0]            enq_src1_tag;
   logic                         enq_src0_rdy;
   logic                         enq_src1_rdy;
   logic [WAKE_PORTS-1:0]        wake_valid;
   logic [WAKE_PORTS*PREG_W-1:0] wake_tag;
   logic                         iss_valid;
   logic                         iss_ready;
   logic [PAYLOAD_W-1:0]         iss_payload;
   logic [PREG_W-1:0]            iss_src0_tag;
   logic [PREG_W-1:0]            iss_src1_tag;
   logic [ID_W-1:0]              iss_id;
   logic                         flush;
   logic [ID_W-1:0]              flush_id;
   logic [$clog2(DEPTH):0]       count;

   modport master (
      output enq_valid, enq_payload, enq_src0_used, enq_src1_used,
             enq_src0_tag, enq_src1_tag, enq_src0_rdy, enq_src1_rdy,
             wake_valid, wake_tag, iss_ready, flush, flush_id,
      input  enq_ready, iss_valid, iss_payload, iss_src0_tag, iss_src1_tag,
             iss_id, count
   );

   modport slave (
      input  enq_valid, enq_payload, enq_src0_used, enq_src1_used,
             enq_src0_tag, enq_src1_tag, enq_src0_rdy, enq_src1_rdy,
             wake_valid, wake_tag, iss_ready, flush, flush_id,
      output enq_ready, iss_valid, iss_payload, iss_src0_tag, iss_src1_tag,
             iss_id, count
   );
endinterface

// File: rtl/issue_queue_ooo.sv
// Age-ordered out-of-order issue queue with tag-broadcast wakeup and ID-based flush.
// Optional macro ISSUE_QUEUE_WAKE_BYPASS_EN: enqueuing sources also catch same-cycle wake broadcasts.
module issue_queue_ooo #(
   parameter int DEPTH      = 32,
   parameter int PREG_W     = 6,
   parameter int PAYLOAD_W  = 64,
   parameter int ID_W       = 32,
   parameter int WAKE_PORTS = 2
) (
   input logic              clk,
   input logic              rst,
   issue_queue_ooo_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [DEPTH-1:0]     valid_r;
   logic [DEPTH-1:0]     rdy0_r;
   logic [DEPTH-1:0]     rdy1_r;
   logic [ID_W-1:0]      id_r      [DEPTH];
   logic [PAYLOAD_W-1:0] payload_r [DEPTH];
   logic [PREG_W-1:0]    tag0_r    [DEPTH];
   logic [PREG_W-1:0]    tag1_r    [DEPTH];
   logic [ID_W-1:0]      next_id_r;
   logic [CNT_W-1:0]     count_r;

   logic                 iss_valid_r;
   logic [PAYLOAD_W-1:0] iss_payload_r;
   logic [PREG_W-1:0]    iss_tag0_r;
   logic [PREG_W-1:0]    iss_tag1_r;
   logic [ID_W-1:0]      iss_id_r;

   logic                 sel_found_s;
   logic [IDX_W-1:0]     sel_idx_s;
   logic [IDX_W-1:0]     free_idx_s;
   logic                 enq_ready_s;
   logic                 enq_fire_s;
   logic                 out_free_s;
   logic                 deq_fire_s;
   logic                 enq_rdy0_s;
   logic                 enq_rdy1_s;
   logic [DEPTH-1:0]     valid_nx_s;
   logic [CNT_W-1:0]     count_nx_s;

   // Wrap-aware age: a is older than b when (a - b) is negative over ID_W bits.
   function automatic logic is_older(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
      logic [ID_W-1:0] diff;
      diff = a - b;
      return diff[ID_W-1];
   endfunction

   function automatic logic is_younger(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
      logic [ID_W-1:0] diff;
      diff = a - b;
      return ~diff[ID_W-1] & (diff != {ID_W{1'b0}});
   endfunction

   function automatic logic wake_hit(input logic [PREG_W-1:0]            tag,
                                     input logic [WAKE_PORTS-1:0]        wv,
                                     input logic [WAKE_PORTS*PREG_W-1:0] wt);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < WAKE_PORTS; p++) begin
         hit = hit | (wv[p] & (wt[p*PREG_W +: PREG_W] == tag));
      end
      return hit;
   endfunction

   // Oldest-ready select over registered ready bits only.
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_r[i] && rdy0_r[i] && rdy1_r[i] &&
             (!sel_found_s || is_older(id_r[i], id_r[sel_idx_s]))) begin
            sel_found_s = 1'b1;
            sel_idx_s   = IDX_W'(i);
         end else begin
            sel_found_s = sel_found_s;
         end
      end
   end

   // Lowest-index free slot; scanning downward leaves the lowest one last.
   always_comb begin
      free_idx_s = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_r[i]) begin
            free_idx_s = IDX_W'(i);
         end else begin
            free_idx_s = free_idx_s;
         end
      end
   end

   assign enq_ready_s = ~rst & ~bus.flush & (count_r < CNT_W'(DEPTH));
   assign enq_fire_s  = bus.enq_valid & enq_ready_s;
   assign out_free_s  = ~iss_valid_r | bus.iss_ready;
   assign deq_fire_s  = ~bus.flush & out_free_s & sel_found_s;

`ifdef ISSUE_QUEUE_WAKE_BYPASS_EN
   assign enq_rdy0_s = ~bus.enq_src0_used | bus.enq_src0_rdy |
                       wake_hit(bus.enq_src0_tag, bus.wake_valid, bus.wake_tag);
   assign enq_rdy1_s = ~bus.enq_src1_used | bus.enq_src1_rdy |
                       wake_hit(bus.enq_src1_tag, bus.wake_valid, bus.wake_tag);
`else
   assign enq_rdy0_s = ~bus.enq_src0_used | bus.enq_src0_rdy;
   assign enq_rdy1_s = ~bus.enq_src1_used | bus.enq_src1_rdy;
`endif

   // Next occupancy vector: flush squash, dequeue and enqueue never touch the same slot.
   always_comb begin
      valid_nx_s = valid_r;
      count_nx_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.flush && is_younger(id_r[i], bus.flush_id)) begin
            valid_nx_s[i] = 1'b0;
         end else begin
            valid_nx_s[i] = valid_nx_s[i];
         end
      end
      if (deq_fire_s) begin
         valid_nx_s[sel_idx_s] = 1'b0;
      end else begin
         valid_nx_s = valid_nx_s;
      end
      if (enq_fire_s) begin
         valid_nx_s[free_idx_s] = 1'b1;
      end else begin
         valid_nx_s = valid_nx_s;
      end
      for (int i = 0; i < DEPTH; i++) begin
         count_nx_s = count_nx_s + CNT_W'(valid_nx_s[i]);
      end
   end

   // Entry valid/ready state, ID counter and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r   <= '0;
         rdy0_r    <= '0;
         rdy1_r    <= '0;
         next_id_r <= '0;
         count_r   <= '0;
      end else begin
         valid_r <= valid_nx_s;
         count_r <= count_nx_s;
         for (int i = 0; i < DEPTH; i++) begin
            rdy0_r[i] <= rdy0_r[i] | wake_hit(tag0_r[i], bus.wake_valid, bus.wake_tag);
            rdy1_r[i] <= rdy1_r[i] | wake_hit(tag1_r[i], bus.wake_valid, bus.wake_tag);
         end
         if (enq_fire_s) begin
            rdy0_r[free_idx_s] <= enq_rdy0_s;
            rdy1_r[free_idx_s] <= enq_rdy1_s;
         end
         if (bus.flush) begin
            next_id_r <= bus.flush_id + {{(ID_W-1){1'b0}}, 1'b1};
         end else if (enq_fire_s) begin
            next_id_r <= next_id_r + {{(ID_W-1){1'b0}}, 1'b1};
         end else begin
            next_id_r <= next_id_r;
         end
      end
   end

   // Entry data storage; meaningless until the slot's valid bit is set.
   always_ff @(posedge clk) begin
      if (enq_fire_s) begin
         id_r[free_idx_s]      <= next_id_r;
         payload_r[free_idx_s] <= bus.enq_payload;
         tag0_r[free_idx_s]    <= bus.enq_src0_tag;
         tag1_r[free_idx_s]    <= bus.enq_src1_tag;
      end
   end

   // Output register: a flush drops a consumed or younger entry and never loads a new one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_valid_r   <= 1'b0;
         iss_payload_r <= '0;
         iss_tag0_r    <= '0;
         iss_tag1_r    <= '0;
         iss_id_r      <= '0;
      end else if (bus.flush) begin
         if (iss_valid_r && (bus.iss_ready || is_younger(iss_id_r, bus.flush_id))) begin
            iss_valid_r <= 1'b0;
         end else begin
            iss_valid_r <= iss_valid_r;
         end
      end else if (out_free_s) begin
         iss_valid_r <= sel_found_s;
         if (sel_found_s) begin
            iss_payload_r <= payload_r[sel_idx_s];
            iss_tag0_r    <= tag0_r[sel_idx_s];
            iss_tag1_r    <= tag1_r[sel_idx_s];
            iss_id_r      <= id_r[sel_idx_s];
         end
      end else begin
         iss_valid_r <= iss_valid_r;
      end
   end

   assign bus.enq_ready    = enq_ready_s;
   assign bus.iss_valid    = iss_valid_r;
   assign bus.iss_payload  = iss_payload_r;
   assign bus.iss_src0_tag = iss_tag0_r;
   assign bus.iss_src1_tag = iss_tag1_r;
   assign bus.iss_id       = iss_id_r;
   assign bus.count        = count_r;
endmodule

// File: tb/tb_issue_queue_ooo.sv
// Scoreboard bench for issue_queue_ooo (DEPTH=4): directed enqueue/wake/flush sequences,
// expected issues queued at stimulus time and compared by a negedge monitor.
`timescale 1ns/1ps
module tb_issue_queue_ooo;
   localparam int DEPTH      = 4;
   localparam int PREG_W     = 6;
   localparam int PAYLOAD_W  = 64;
   localparam int ID_W       = 32;
   localparam int WAKE_PORTS = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   issue_queue_ooo_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W),
                        .ID_W(ID_W), .WAKE_PORTS(WAKE_PORTS)) bus ();

   issue_queue_ooo #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W),
                     .ID_W(ID_W), .WAKE_PORTS(WAKE_PORTS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      logic [ID_W-1:0]      id;
      logic [PREG_W-1:0]    t0;
      logic [PREG_W-1:0]    t1;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic void push(input logic [63:0] pl, input logic [31:0] id, input logic [5:0] t0);
      exp_t e;
      e.payload = pl;
      e.id      = id;
      e.t0      = t0;
      e.t1      = 6'h2A;
      exp_q.push_back(e);
   endfunction

   // Enqueue one instruction; src1 is always an unused operand with tag 0x2A.
   task automatic enq(input logic [63:0] pl, input logic u0, input logic [5:0] t0,
                      input logic r0, output logic acc);
      bus.enq_valid     = 1'b1;
      bus.enq_payload   = pl;
      bus.enq_src0_used = u0;
      bus.enq_src0_tag  = t0;
      bus.enq_src0_rdy  = r0;
      bus.enq_src1_used = 1'b0;
      bus.enq_src1_tag  = 6'h2A;
      bus.enq_src1_rdy  = 1'b0;
      @(negedge clk);
      acc = bus.enq_ready;
      @(posedge clk);
      #1;
      bus.enq_valid = 1'b0;
   endtask

   task automatic do_flush(input logic [31:0] fid);
      bus.flush    = 1'b1;
      bus.flush_id = fid;
      @(negedge clk);
      check("enq_ready_during_flush", 64'(bus.enq_ready), 64'd0);
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
   endtask

   task automatic drain(input string name);
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL %s_timeout: got %0d outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
      check({name, "_count_empty"}, 64'(bus.count), 64'd0);
      check({name, "_iss_idle"}, 64'(bus.iss_valid), 64'd0);
   endtask

   // Monitor: every handshake on the issue port must match the oldest expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.iss_valid && bus.iss_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_issue: got id %0h, expected none", bus.iss_id);
            end else begin
               e = exp_q.pop_front();
               check("iss_id", 64'(bus.iss_id), 64'(e.id));
               check("iss_payload", bus.iss_payload, e.payload);
               check("iss_src0_tag", 64'(bus.iss_src0_tag), 64'(e.t0));
               check("iss_src1_tag", 64'(bus.iss_src1_tag), 64'(e.t1));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200us");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic acc;
      bus.enq_valid     = 1'b0;
      bus.enq_payload   = 64'd0;
      bus.enq_src0_used = 1'b0;
      bus.enq_src1_used = 1'b0;
      bus.enq_src0_tag  = 6'd0;
      bus.enq_src1_tag  = 6'd0;
      bus.enq_src0_rdy  = 1'b0;
      bus.enq_src1_rdy  = 1'b0;
      bus.wake_valid    = 2'b00;
      bus.wake_tag      = 12'd0;
      bus.iss_ready     = 1'b0;
      bus.flush         = 1'b0;
      bus.flush_id      = 32'd0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_enq_ready", 64'(bus.enq_ready), 64'd0);
      check("rst_iss_id", 64'(bus.iss_id), 64'd0);
      check("rst_iss_payload", bus.iss_payload, 64'd0);
      rst = 1'b0;
      #1;
      check("enq_ready_after_rst", 64'(bus.enq_ready), 64'd1);

      // Reset mid-operation: 4 entries plus one in the output register.
      for (int i = 0; i < 5; i++) begin
         enq(64'h100 + 64'(i), 1'b0, 6'd1, 1'b0, acc);
      end
      check("fill_count", 64'(bus.count), 64'd4);
      check("fill_iss_valid", 64'(bus.iss_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_count", 64'(bus.count), 64'd0);
      check("async_rst_iss_valid", 64'(bus.iss_valid), 64'd0);
      check("async_rst_enq_ready", 64'(bus.enq_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.iss_ready = 1'b1;
      enq(64'hA0, 1'b0, 6'd3, 1'b0, acc);
      push(64'hA0, 32'd0, 6'd3);
      drain("reset_restart");

      // Age order A,B,C with two-edge latency.
      enq(64'hA1, 1'b0, 6'd4, 1'b0, acc);
      push(64'hA1, 32'd1, 6'd4);
      check("latency_edge1", 64'(bus.iss_valid), 64'd0);
      enq(64'hB1, 1'b0, 6'd5, 1'b0, acc);
      push(64'hB1, 32'd2, 6'd5);
      check("latency_edge2", 64'(bus.iss_valid), 64'd1);
      enq(64'hC1, 1'b0, 6'd6, 1'b0, acc);
      push(64'hC1, 32'd3, 6'd6);
      drain("age_order");

      // Out-of-order wakeup: A waits on tag 7, B overtakes it.
      push(64'hB2, 32'd5, 6'd8);
      push(64'hA2, 32'd4, 6'd7);
      enq(64'hA2, 1'b1, 6'd7, 1'b0, acc);
      enq(64'hB2, 1'b0, 6'd8, 1'b0, acc);
      @(posedge clk);
      #1;
      check("ooo_b_first", 64'(bus.iss_id), 64'd5);
      @(posedge clk);
      #1;
      check("ooo_a_blocked", 64'(bus.iss_valid), 64'd0);
      bus.wake_valid = 2'b10;
      bus.wake_tag   = {6'd7, 6'd0};
      @(posedge clk);
      #1;
      bus.wake_valid = 2'b00;
      check("ooo_no_same_cycle", 64'(bus.iss_valid), 64'd0);
      @(posedge clk);
      #1;
      check("ooo_a_after_wake", 64'(bus.iss_valid), 64'd1);
      drain("wakeup");

      // Backpressure / full: five accepted (4 entries + output register), sixth refused.
      bus.iss_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         enq(64'hB0 + 64'(i), 1'b0, 6'd10, 1'b0, acc);
         check("bp_accept", 64'(acc), (i < 5) ? 64'd1 : 64'd0);
         if (acc) begin
            push(64'hB0 + 64'(i), 32'd6 + 32'(i), 6'd10);
         end
      end
      check("full_count", 64'(bus.count), 64'd4);
      check("full_enq_ready", 64'(bus.enq_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         check("bp_iss_valid_hold", 64'(bus.iss_valid), 64'd1);
         check("bp_payload_hold", bus.iss_payload, 64'hB0);
         @(posedge clk);
         #1;
      end
      bus.iss_ready = 1'b1;
      drain("backpressure");

      // Flush with ID wrap: preset next_id to 0xFFFFFFFE through an empty-queue flush.
      bus.iss_ready = 1'b0;
      do_flush(32'hFFFF_FFFD);
      enq(64'hF0, 1'b0, 6'd11, 1'b0, acc);
      push(64'hF0, 32'hFFFF_FFFE, 6'd11);
      enq(64'hF1, 1'b0, 6'd12, 1'b0, acc);
      push(64'hF1, 32'hFFFF_FFFF, 6'd12);
      enq(64'hF2, 1'b0, 6'd13, 1'b0, acc);
      enq(64'hF3, 1'b0, 6'd14, 1'b0, acc);
      check("wrap_count", 64'(bus.count), 64'd3);
      do_flush(32'hFFFF_FFFF);
      check("flush_count", 64'(bus.count), 64'd1);
      check("flush_iss_valid", 64'(bus.iss_valid), 64'd1);
      check("flush_iss_id", 64'(bus.iss_id), 64'hFFFF_FFFE);
      enq(64'hF4, 1'b0, 6'd15, 1'b0, acc);
      push(64'hF4, 32'd0, 6'd15);
      bus.iss_ready = 1'b1;
      drain("flush_wrap");

      // Same-cycle wake of an enqueuing source (tag 9).
      bus.wake_valid = 2'b01;
      bus.wake_tag   = {6'd0, 6'd9};
      push(64'hD0, 32'd1, 6'd9);
      enq(64'hD0, 1'b1, 6'd9, 1'b0, acc);
      bus.wake_valid = 2'b00;
`ifdef ISSUE_QUEUE_WAKE_BYPASS_EN
      @(posedge clk);
      #1;
      check("bypass_issue", 64'(bus.iss_valid), 64'd1);
`else
      repeat (10) @(posedge clk);
      #1;
      check("no_bypass_stuck", 64'(bus.iss_valid), 64'd0);
      check("no_bypass_count", 64'(bus.count), 64'd1);
      bus.wake_valid = 2'b01;
      bus.wake_tag   = {6'd0, 6'd9};
      @(posedge clk);
      #1;
      bus.wake_valid = 2'b00;
`endif
      drain("bypass");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
